furv_dmem: RTL and testbench

- Data-memory responder at the far end of the execute/memory-stage load/store request interface.
- Accepts one word-addressed request at a time, with byte enables, pre-replicated store data, width, signedness and byte offset.
- Applies LATENCY wait states, then performs the masked write or the read against an internal word array.
- Returns aligned, sign- or zero-extended load data to writeback, and back-pressures the pipeline through stall_o while busy.

---
 rtl/furv_dmem.sv | 133 +++++++++++++
 tb/tb_furv_dmem.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/furv_dmem.sv
// Data-memory responder for the load/store stage: serializes one request at a time,
// inserts LATENCY wait states, then performs a masked store or an aligned/extended load.
module furv_dmem #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [3:0]  sel_i,
  input  logic [29:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  input  logic [1:0]  byte_addr_i,
  output logic        stall_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q;

  logic          wr_p0;
  logic          uns_p0;
  logic [3:0]    sel_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0]   wdata_p0;
  logic [1:0]    width_p0;
  logic [1:0]    boff_p0;

  logic [31:0] mem [DEPTH];

  logic accept;
  logic access;
  logic misaligned;

  // Upper address bits are intentionally dropped so accesses wrap around the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[29:AW];

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] boff);
    case (width)
      2'd0:    return 1'b0;
      2'd1:    return boff[0];
      default: return boff != 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] width,
                                              input logic uns, input logic [1:0] boff);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        sh_b;
    logic [31:0]        sh_h;
    sh_b = word >> {boff, 3'b000};
    sh_h = word >> {boff[1], 4'b0000};
    b_s  = sh_b[7:0];
    h_s  = sh_h[15:0];
    case (width)
      2'd0:    return uns ? {24'h0, b_s} : {{24{b_s[7]}}, b_s};
      2'd1:    return uns ? {16'h0, h_s} : {{16{h_s[15]}}, h_s};
      default: return word;
    endcase
  endfunction

  assign accept     = (state_q == IDLE) && req_i;
  assign access     = (state_q == BUSY) && (cnt_q == 4'd0);
  assign misaligned = is_misaligned(width_p0, boff_p0);

  assign stall_o  = (state_q == BUSY) || accept;
  assign rvalid_o = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_o <= 32'h0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= 4'(LATENCY);
      end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        err_o   <= misaligned;
        rdata_o <= (misaligned || wr_p0) ? 32'h0
                 : load_extend(mem[idx_p0], width_p0, uns_p0, boff_p0);
      end
    end
  end

  // p0: request fields captured on acceptance and held through BUSY/DONE
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= write_i;
      uns_p0   <= unsigned_i;
      sel_p0   <= sel_i;
      idx_p0   <= addr_i[AW-1:0];
      wdata_p0 <= data_i;
      width_p0 <= width_i;
      boff_p0  <= byte_addr_i;
    end
  end

  // Reset abandons an in-flight store, so the write is gated by rst as well.
  always_ff @(posedge clk) begin
    if (!rst && access && wr_p0 && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_p0[i]) mem[idx_p0][8*i +: 8] <= wdata_p0[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_furv_dmem.sv
// Bench for furv_dmem: two instances (LATENCY 0 and 3) exercised with directed
// scenarios and randomized transactions compared against a behavioural memory model.
module tb_furv_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req;
  logic [1:0]       wr;
  logic [1:0]       uns;
  logic [1:0][3:0]  sel;
  logic [1:0][29:0] addr;
  logic [1:0][31:0] data;
  logic [1:0][1:0]  width;
  logic [1:0][1:0]  boff;

  logic        stall0, rvalid0, err0, stall3, rvalid3, err3;
  logic [31:0] rdata0, rdata3;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0] model [2][1024];

  furv_dmem #(.DEPTH(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_i(req[0]), .write_i(wr[0]), .sel_i(sel[0]),
    .addr_i(addr[0]), .data_i(data[0]), .width_i(width[0]), .unsigned_i(uns[0]),
    .byte_addr_i(boff[0]), .stall_o(stall0), .rvalid_o(rvalid0), .rdata_o(rdata0),
    .err_o(err0)
  );

  furv_dmem #(.DEPTH(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_i(req[1]), .write_i(wr[1]), .sel_i(sel[1]),
    .addr_i(addr[1]), .data_i(data[1]), .width_i(width[1]), .unsigned_i(uns[1]),
    .byte_addr_i(boff[1]), .stall_o(stall3), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .err_o(err3)
  );

  function automatic logic get_stall(input int d);
    return (d == 0) ? stall0 : stall3;
  endfunction
  function automatic logic get_rvalid(input int d);
    return (d == 0) ? rvalid0 : rvalid3;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err0 : err3;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? rdata0 : rdata3;
  endfunction
  function automatic int lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Behavioural model: applies one transaction to the word array and predicts the response.
  task automatic model_apply(input int d, input logic w, input logic [3:0] s, input logic [29:0] a,
                             input logic [31:0] dat, input logic [1:0] wd, input logic u,
                             input logic [1:0] b, output logic [31:0] rd, output logic e);
    int idx;
    int v;
    logic [31:0] word;
    logic mis;
    idx = int'(a) % 1024;
    mis = (wd == 2'd1 && (b % 2) == 1) || (wd >= 2'd2 && b != 2'd0);
    rd = 32'h0;
    e  = mis;
    if (!mis) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) model[d][idx][8*i +: 8] = dat[8*i +: 8];
      end else begin
        word = model[d][idx];
        if (wd == 2'd0) begin
          v = int'((word / (32'd1 << (8 * b))) % 256);
          if (!u && v >= 128) v = v - 256;
          rd = 32'(v);
        end else if (wd == 2'd1) begin
          v = int'((word / (32'd1 << (16 * (b / 2)))) % 65536);
          if (!u && v >= 32768) v = v - 65536;
          rd = 32'(v);
        end else begin
          rd = word;
        end
      end
    end
  endtask

  // Presents one request and holds it until the completion pulse (bounded at 40 cycles).
  task automatic txn(input int d, input logic w, input logic [3:0] s, input logic [29:0] a,
                     input logic [31:0] dat, input logic [1:0] wd, input logic u,
                     input logic [1:0] b, output logic [31:0] rd, output logic e,
                     output int cyc, output logic stall_ok, output logic done_stall);
    @(negedge clk);
    req[d] = 1'b1; wr[d] = w; sel[d] = s; addr[d] = a; data[d] = dat;
    width[d] = wd; uns[d] = u; boff[d] = b;
    #1;
    cyc = 0;
    stall_ok = 1'b1;
    while (!get_rvalid(d) && cyc < 40) begin
      if (!get_stall(d)) stall_ok = 1'b0;
      cyc++;
      @(negedge clk); #1;
    end
    rd = get_rdata(d);
    e = get_err(d);
    done_stall = get_stall(d);
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 2'b11; req = '0; wr = '0; uns = '0; sel = '0; addr = '0; data = '0;
    width = '0; boff = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++; if ({stall0, rvalid0, err0} !== 3'b000) begin
      $display("FAIL reset_ctl0 got %b want 000", {stall0, rvalid0, err0});
    end else pass_cnt++;
    total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0 got %h want 0", rdata0);
    else pass_cnt++;
    total++; if ({stall3, rvalid3, err3} !== 3'b000) begin
      $display("FAIL reset_ctl3 got %b want 000", {stall3, rvalid3, err3});
    end else pass_cnt++;
    total++; if (rdata3 !== 32'h0) $display("FAIL reset_rdata3 got %h want 0", rdata3);
    else pass_cnt++;
    rst = 2'b00;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic e, sok, dst; int cyc;
    txn(0, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (cyc !== 2 || !sok || dst !== 1'b0)
      $display("FAIL st_timing got cyc=%0d stall_ok=%b done_stall=%b want 2/1/0", cyc, sok, dst);
    else pass_cnt++;
    total++; if (e !== 1'b0 || rd !== 32'h0) $display("FAIL st_resp got err=%b rd=%h want 0/0", e, rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL ld_word got %h err=%b want deadbeef/0", rd, e);
    else pass_cnt++;
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e, sok, dst; int cyc;
    txn(0, 1'b1, 4'b0100, 30'd5, 32'h80808080, 2'd0, 1'b0, 2'd2, rd, e, cyc, sok, dst);
    total++; if (e !== 1'b0) $display("FAIL st_byte_err got %b want 0", e); else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hDE80BEEF) $display("FAIL merged_word got %h want de80beef", rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd0, 1'b0, 2'd2, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hFFFFFF80) $display("FAIL ld_byte_s got %h want ffffff80", rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd0, 1'b1, 2'd2, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'h00000080) $display("FAIL ld_byte_u got %h want 00000080", rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd1, 1'b0, 2'd2, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hFFFFDE80) $display("FAIL ld_half_s got %h want ffffde80", rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd1, 1'b0, 2'd1, rd, e, cyc, sok, dst);
    total++; if (e !== 1'b1 || rd !== 32'h0)
      $display("FAIL mis_half got err=%b rd=%h want 1/0", e, rd);
    else pass_cnt++;
    txn(0, 1'b1, 4'hF, 30'd5, 32'h12345678, 2'd2, 1'b0, 2'd3, rd, e, cyc, sok, dst);
    total++; if (e !== 1'b1 || rd !== 32'h0)
      $display("FAIL mis_word_st got err=%b rd=%h want 1/0", e, rd);
    else pass_cnt++;
    txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hDE80BEEF) $display("FAIL mis_no_write got %h want de80beef", rd);
    else pass_cnt++;
  endtask

  task automatic test_held_request();
    logic [31:0] rd; logic e, sok, dst; int cyc; int n;
    txn(1, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (cyc !== 5 || !sok || dst !== 1'b0)
      $display("FAIL lat3_timing got cyc=%0d stall_ok=%b done_stall=%b want 5/1/0", cyc, sok, dst);
    else pass_cnt++;
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 30'd5; width[1] = 2'd2; boff[1] = 2'd0; uns[1] = 1'b0;
    #1;
    n = 0;
    while (stall3 && n < 20) begin n++; @(negedge clk); #1; end
    total++; if (n !== 5 || rvalid3 !== 1'b1)
      $display("FAIL held_first got stall_cycles=%0d rvalid=%b want 5/1", n, rvalid3);
    else pass_cnt++;
    @(negedge clk); #1;
    total++; if (stall3 !== 1'b1 || rvalid3 !== 1'b0)
      $display("FAIL held_reaccept got stall=%b rvalid=%b want 1/0", stall3, rvalid3);
    else pass_cnt++;
    n = 0;
    while (stall3 && n < 20) begin n++; @(negedge clk); #1; end
    total++; if (n !== 5 || rvalid3 !== 1'b1 || rdata3 !== 32'hDEADBEEF)
      $display("FAIL held_second got stall_cycles=%0d rvalid=%b rd=%h want 5/1/deadbeef",
               n, rvalid3, rdata3);
    else pass_cnt++;
    req[1] = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic e, sok, dst; int cyc; logic seen;
    txn(1, 1'b1, 4'hF, 30'd7, 32'h11112222, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    txn(1, 1'b0, 4'h0, 30'd5, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; sel[1] = 4'hF; addr[1] = 30'd7; data[1] = 32'hCAFEF00D;
    width[1] = 2'd2; boff[1] = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1; req[1] = 1'b0;
    @(negedge clk); #1;
    total++; if ({stall3, rvalid3, err3} !== 3'b000 || rdata3 !== 32'h0)
      $display("FAIL busy_reset got ctl=%b rd=%h want 000/0", {stall3, rvalid3, err3}, rdata3);
    else pass_cnt++;
    rst[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (rvalid3) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("FAIL busy_reset_pulse got %b want 0", seen);
    else pass_cnt++;
    txn(1, 1'b0, 4'h0, 30'd7, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'h11112222) $display("FAIL busy_reset_nowrite got %h want 11112222", rd);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic e, sok, dst; int cyc;
    txn(0, 1'b1, 4'hF, 30'h400, 32'hA5A55A5A, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    txn(0, 1'b0, 4'h0, 30'd0, 32'h0, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
    total++; if (rd !== 32'hA5A55A5A || e !== 1'b0)
      $display("FAIL wrap got %h err=%b want a5a55a5a/0", rd, e);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, dat; logic e, exp_e, sok, dst, w, u; int cyc, d;
    logic [3:0] s; logic [29:0] a; logic [1:0] wd, b;
    for (int dd = 0; dd < 2; dd++) begin
      for (int k = 0; k < 8; k++) begin
        dat = $urandom;
        model_apply(dd, 1'b1, 4'hF, 30'(k), dat, 2'd2, 1'b0, 2'd0, exp_rd, exp_e);
        txn(dd, 1'b1, 4'hF, 30'(k), dat, 2'd2, 1'b0, 2'd0, rd, e, cyc, sok, dst);
      end
    end
    for (int it = 0; it < 60; it++) begin
      d = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1)); s = 4'($urandom); dat = $urandom;
      a = 30'($urandom_range(0, 7) + 1024 * $urandom_range(0, 3));
      wd = 2'($urandom); u = 1'($urandom_range(0, 1)); b = 2'($urandom);
      model_apply(d, w, s, a, dat, wd, u, b, exp_rd, exp_e);
      txn(d, w, s, a, dat, wd, u, b, rd, e, cyc, sok, dst);
      total++; if (rd !== exp_rd || e !== exp_e)
        $display("FAIL rand_resp it=%0d dut=%0d w=%b wd=%0d b=%0d got %h/%b want %h/%b",
                 it, d, w, wd, b, rd, e, exp_rd, exp_e);
      else pass_cnt++;
      total++; if (cyc !== lat(d) + 2 || !sok || dst !== 1'b0)
        $display("FAIL rand_timing it=%0d got cyc=%0d stall_ok=%b done_stall=%b want %0d/1/0",
                 it, cyc, sok, dst, lat(d) + 2);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword();
    test_held_request();
    test_reset_busy();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
